dualportram_be: RTL and testbench

Parametrised true dual-port synchronous RAM, successor to the simple single-port-pair RAM used by generated hardware objects. Two independent read/write ports (A and B) share one memory array and one clock. Each port has byte-lane write enables and a configurable read latency of 1 or 2 cycles. Each port also has a read-valid strobe and a selectable read-during-write mode. The block backs array instances that are accessed concurrently by two state machines, for example a producer/consumer pair or a method and a port accessor.

---
 rtl/dualportram_be.sv | 104 ++++++++++
 tb/tb_dualportram_be.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dualportram_be.sv
// True dual-port RAM with byte-lane write enables, 1- or 2-cycle registered
// reads, per-port read-valid strobes and selectable same-port read-during-write.
module dualportram_be #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned READ_MODE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        length,
  input  logic [31:0]        address_a,
  input  logic [WIDTH-1:0]   din_a,
  input  logic [WIDTH/8-1:0] be_a,
  input  logic               we_a,
  input  logic               oe_a,
  output logic [WIDTH-1:0]   dout_a,
  output logic               valid_a,
  input  logic [31:0]        address_b,
  input  logic [WIDTH-1:0]   din_b,
  input  logic [WIDTH/8-1:0] be_b,
  input  logic               we_b,
  input  logic               oe_b,
  output logic [WIDTH-1:0]   dout_b,
  output logic               valid_b
);

  localparam int unsigned NB = WIDTH / 8;

  logic [DEPTH-1:0] idx_a, idx_b;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] s1_data_a, s1_data_b;
  logic             s1_valid_a, s1_valid_b;
  logic [WIDTH-1:0] src_data_a, src_data_b;
  logic             src_valid_a, src_valid_b;
  logic             unused_addr;

  assign length      = 32'(WORDS);
  assign idx_a       = address_a[DEPTH-1:0];
  assign idx_b       = address_b[DEPTH-1:0];
  assign unused_addr = ^{address_a[31:DEPTH], address_b[31:DEPTH]};

  // One byte-wide array per lane; within a lane port A is written last so it
  // wins when both ports hit the same word and lane.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [7:0] ram [2**DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        // contents survive reset; reset only blocks writes
      end else begin
        if (we_b && be_b[l]) ram[idx_b] <= din_b[8*l +: 8];
        if (we_a && be_a[l]) ram[idx_a] <= din_a[8*l +: 8];
      end
    end

    // Cross-port reads always see the pre-write lane; same-port bypass only in write-first mode.
    assign rd_a[8*l +: 8] = (READ_MODE == 1 && we_a && be_a[l]) ? din_a[8*l +: 8] : ram[idx_a];
    assign rd_b[8*l +: 8] = (READ_MODE == 1 && we_b && be_b[l]) ? din_b[8*l +: 8] : ram[idx_b];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_a <= 1'b0;
      s1_valid_b <= 1'b0;
      s1_data_a  <= '0;
      s1_data_b  <= '0;
    end else begin
      s1_valid_a <= oe_a;
      s1_valid_b <= oe_b;
      if (oe_a) s1_data_a <= rd_a;
      if (oe_b) s1_data_b <= rd_b;
    end
  end

  always_comb begin
    src_valid_a = oe_a;
    src_valid_b = oe_b;
    src_data_a  = rd_a;
    src_data_b  = rd_b;
    if (RD_LATENCY == 2) begin
      src_valid_a = s1_valid_a;
      src_valid_b = s1_valid_b;
      src_data_a  = s1_data_a;
      src_data_b  = s1_data_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      dout_a  <= '0;
      dout_b  <= '0;
    end else begin
      valid_a <= src_valid_a;
      valid_b <= src_valid_b;
      if (src_valid_a) dout_a <= src_data_a;
      if (src_valid_b) dout_b <= src_data_b;
    end
  end

endmodule

// File: tb/tb_dualportram_be.sv
// Scoreboard bench for dualportram_be: four instances (latency 1/2 x read-first/write-first)
// share one stimulus stream and are checked against a word-array reference model.
module tb_dualportram_be;

  localparam int unsigned W     = 32;
  localparam int unsigned NB    = W / 8;
  localparam int unsigned WORDS = 1024;
  localparam int          NI    = 4;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  due;
    bit           has_k;
    logic [W-1:0] k;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   address_a, address_b;
  logic [W-1:0]  din_a, din_b;
  logic [NB-1:0] be_a, be_b;
  logic          we_a, we_b, oe_a, oe_b;

  logic [31:0]   length_w  [NI];
  logic [W-1:0]  dout_a_w  [NI];
  logic [W-1:0]  dout_b_w  [NI];
  logic          valid_a_w [NI];
  logic          valid_b_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dualportram_be #(
      .WIDTH(W), .DEPTH(10), .WORDS(WORDS),
      .RD_LATENCY(g / 2 + 1), .READ_MODE(g % 2)
    ) dut (
      .clk(clk), .reset(reset), .length(length_w[g]),
      .address_a(address_a), .din_a(din_a), .be_a(be_a), .we_a(we_a), .oe_a(oe_a),
      .dout_a(dout_a_w[g]), .valid_a(valid_a_w[g]),
      .address_b(address_b), .din_b(din_b), .be_b(be_b), .we_b(we_b), .oe_b(oe_b),
      .dout_b(dout_b_w[g]), .valid_b(valid_b_w[g])
    );
  end

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         q [NI*2][$];
  logic [W-1:0] ref_mem [WORDS];
  logic [W-1:0] last_out [NI*2];
  bit           pin_on [2];
  logic [W-1:0] pin_v [2][2];
  int unsigned  n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                         input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic pin(input int p, input logic [W-1:0] v_rf, input logic [W-1:0] v_wf);
    pin_on[p]   = 1'b1;
    pin_v[0][p] = v_rf;
    pin_v[1][p] = v_wf;
  endtask

  // Presents one cycle of inputs, updates the model, then advances past the edge.
  task automatic drive(input bit rst,
                       input bit wa, input bit oa, input logic [31:0] aa,
                       input logic [W-1:0] da, input logic [NB-1:0] bea,
                       input bit wb, input bit ob, input logic [31:0] ab,
                       input logic [W-1:0] db, input logic [NB-1:0] beb);
    int unsigned ia, ib;
    logic [W-1:0] v;
    reset = rst;
    we_a = wa; oe_a = oa; address_a = aa; din_a = da; be_a = bea;
    we_b = wb; oe_b = ob; address_b = ab; din_b = db; be_b = beb;
    ia = aa % WORDS;
    ib = ab % WORDS;
    if (!rst) begin
      for (int i = 0; i < NI*2; i++) begin
        q[i].delete();
        last_out[i] = '0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (oa) begin
          v = ref_mem[ia];
          if (g % 2 == 1 && wa) v = merge(v, da, bea);
          q[g*2].push_back('{v, cyc + g/2 + 1, pin_on[0], pin_v[g%2][0]});
        end
        if (ob) begin
          v = ref_mem[ib];
          if (g % 2 == 1 && wb) v = merge(v, db, beb);
          q[g*2+1].push_back('{v, cyc + g/2 + 1, pin_on[1], pin_v[g%2][1]});
        end
      end
      if (wb) ref_mem[ib] = merge(ref_mem[ib], db, beb);
      if (wa) ref_mem[ia] = merge(ref_mem[ia], da, bea);
    end
    pin_on[0] = 1'b0;
    pin_on[1] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rst);
    for (int i = 0; i < n; i++) drive(rst, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t         e;
    logic         dv;
    logic [W-1:0] dd;
    int           qi;
    for (int g = 0; g < NI; g++) begin
      for (int p = 0; p < 2; p++) begin
        qi = g*2 + p;
        dv = (p == 1) ? valid_b_w[g] : valid_a_w[g];
        dd = (p == 1) ? dout_b_w[g] : dout_a_w[g];
        if (reset === 1'b0) check($sformatf("valid_in_reset i%0d p%0d", g, p), W'(dv), '0);
        if (dv === 1'b1) begin
          if (q[qi].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid i%0d p%0d: valid=1, required 0 (cycle %0d)", g, p, cyc);
          end else begin
            e = q[qi].pop_front();
            check($sformatf("latency i%0d p%0d", g, p), W'(cyc), W'(e.due));
            check($sformatf("rd_data i%0d p%0d", g, p), dd, e.data);
            if (e.has_k) check($sformatf("directed i%0d p%0d", g, p), dd, e.k);
            last_out[qi] = e.data;
          end
        end else begin
          if (q[qi].size() > 0 && q[qi][0].due <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_valid i%0d p%0d: valid=0, required 1 (cycle %0d)", g, p, cyc);
            void'(q[qi].pop_front());
          end
          check($sformatf("hold i%0d p%0d", g, p), dd, last_out[qi]);
        end
      end
    end
  end

  initial begin
    pin_on[0] = 1'b0;
    pin_on[1] = 1'b0;
    idle(3, 0);
    for (int g = 0; g < NI; g++) check($sformatf("length i%0d", g), length_w[g], W'(WORDS));
    idle(1, 1);

    // Fill the whole array so every later read has a defined expectation.
    for (int i = 0; i < int'(WORDS); i++)
      drive(1, 1, 0, i, $urandom, '1, 0, 0, 0, '0, '0);

    // Basic write then cross-port read.
    drive(1, 1, 0, 5, 32'hDEADBEEF, '1, 0, 0, 0, '0, '0);
    pin(1, 32'hDEADBEEF, 32'hDEADBEEF);
    drive(1, 0, 0, 0, '0, '0, 0, 1, 5, '0, '0);
    idle(3, 1);

    // Byte enables.
    drive(1, 1, 0, 7, 32'h11223344, 4'b1111, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 7, 32'hAABBCCDD, 4'b0101, 0, 0, 0, '0, '0);
    pin(0, 32'h11BB33DD, 32'h11BB33DD);
    drive(1, 0, 1, 7, '0, '0, 0, 0, 0, '0, '0);
    idle(3, 1);

    // Same-port and cross-port read during write.
    drive(1, 1, 0, 3, 32'h1, '1, 0, 0, 0, '0, '0);
    pin(0, 32'h1, 32'h2);
    pin(1, 32'h1, 32'h1);
    drive(1, 1, 1, 3, 32'h2, '1, 0, 1, 3, '0, '0);
    idle(3, 1);

    // Write collision on one word.
    drive(1, 1, 0, 9, 32'h0, '1, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 9, 32'hAAAAAAAA, 4'b0011, 1, 0, 9, 32'hBBBBBBBB, 4'b0110);
    pin(0, 32'h00BBAAAA, 32'h00BBAAAA);
    drive(1, 0, 1, 9, '0, '0, 0, 0, 0, '0, '0);
    idle(3, 1);

    // Address wrap with back-to-back reads.
    drive(1, 1, 0, 0, 32'h55, '1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      pin(0, 32'h55, 32'h55);
      drive(1, 0, 1, WORDS, '0, '0, 0, 0, 0, '0, '0);
    end
    idle(4, 1);

    // Reset mid-read; writes presented during reset must be ignored.
    drive(1, 0, 1, 0, '0, '0, 0, 0, 0, '0, '0);
    drive(0, 1, 1, 0, 32'hFFFFFFFF, '1, 1, 1, 0, 32'hEEEEEEEE, '1);
    drive(0, 1, 1, 0, 32'hFFFFFFFF, '1, 0, 0, 0, '0, '0);
    idle(4, 1);
    pin(0, 32'h55, 32'h55);
    drive(1, 0, 1, 0, '0, '0, 0, 0, 0, '0, '0);
    idle(3, 1);

    // Random traffic over a few aliased words to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7), $urandom, 4'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7), $urandom, 4'($urandom));
    end
    idle(6, 1);

    for (int i = 0; i < NI*2; i++) check($sformatf("drain q%0d", i), W'(q[i].size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
